// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the RV32I pipeline controller: FSM state encoding and the
// per-cycle control bundle driven onto the stage latches.
package pipeline_ctrl_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic load_pc;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic kill_if_id;
        logic kill_id_ex;
        logic redirect_valid;
    } pipe_ctrl_t;

    // Uniform bundle: every load set to 'load', both kills to 'kill', no redirect.
    function automatic pipe_ctrl_t ctrl_uniform(input logic load, input logic kill);
        pipe_ctrl_t c;
        c.load_pc        = load;
        c.load_if_id     = load;
        c.load_id_ex     = load;
        c.load_ex_mem    = load;
        c.load_mem_wb    = load;
        c.kill_if_id     = kill;
        c.kill_id_ex     = kill;
        c.redirect_valid = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID consumer and the EX load.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic                 id_valid_i,
    input  logic                 id_uses_rs1_i,
    input  logic                 id_uses_rs2_i,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 ex_valid_i,
    input  logic                 ex_mem_read_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    output logic                 loaduse_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

    // x0 is never a real producer, so a load to x0 never stalls.
    assign loaduse_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != REG_IDX_W'(0))
                       && id_valid_i && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage-latch load/kill and PC redirect control for the RV32I pipeline.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_read,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic                 id_valid,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mispredict,
    input  logic [XLEN-1:0]      ex_target,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 kill_if_id,
    output logic                 kill_id_ex,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [XLEN-1:0]      perf_dstall,
    output logic [XLEN-1:0]      perf_istall,
    output logic [XLEN-1:0]      perf_loaduse,
    output logic [XLEN-1:0]      perf_mispredict
`endif
);

    pipe_ctrl_state_t state_q, state_d;
    logic [XLEN-1:0]  tgt_q, tgt_d;
    pipe_ctrl_t       ctl;
    logic [XLEN-1:0]  redirect_pc_c;
    logic             dstall;
    logic             istall;
    logic             loaduse;

    assign dstall = dmem_req && !dmem_resp;
    assign istall = imem_read && !imem_resp;

    hazard_detect u_hazard_detect (
        .id_valid_i    (id_valid),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .ex_valid_i    (ex_valid),
        .ex_mem_read_i (ex_mem_read),
        .ex_rd_i       (ex_rd),
        .loaduse_o     (loaduse)
    );

    // State and pending redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    // Next state and latch controls; priority dstall > mispredict > loaduse > istall.
    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        ctl           = ctrl_uniform(1'b1, 1'b0);
        redirect_pc_c = '0;

        unique case (state_q)
            RUN: begin
                if (dstall) begin
                    ctl = ctrl_uniform(1'b0, 1'b0);
                end else if (ex_mispredict) begin
                    ctl.kill_if_id = 1'b1;
                    ctl.kill_id_ex = 1'b1;
                    if (istall) begin
                        ctl.load_pc = 1'b0;
                        tgt_d       = ex_target;
                        state_d     = DRAIN;
                    end else begin
                        ctl.redirect_valid = 1'b1;
                        redirect_pc_c      = ex_target;
                    end
                end else if (loaduse) begin
                    ctl.load_pc    = 1'b0;
                    ctl.load_if_id = 1'b0;
                    ctl.kill_id_ex = 1'b1;
                end else if (istall) begin
                    ctl.load_pc    = 1'b0;
                    ctl.kill_if_id = 1'b1;
                end
            end

            DRAIN, REDIRECT: begin
                // Wrong-path fetch keeps being squashed until the target is issued.
                if (dstall) begin
                    ctl = ctrl_uniform(1'b0, 1'b0);
                    if (state_q == DRAIN && imem_resp) begin
                        state_d = REDIRECT;
                    end
                end else if (state_q == REDIRECT || imem_resp) begin
                    ctl.redirect_valid = 1'b1;
                    redirect_pc_c      = tgt_q;
                    state_d            = RUN;
                end else begin
                    ctl.load_pc = 1'b0;
                end
                ctl.kill_if_id = 1'b1;
            end

            default: begin
                state_d = RUN;
            end
        endcase

        if (rst) begin
            ctl           = ctrl_uniform(1'b0, 1'b1);
            redirect_pc_c = '0;
        end
    end

    assign load_pc        = ctl.load_pc;
    assign load_if_id     = ctl.load_if_id;
    assign load_id_ex     = ctl.load_id_ex;
    assign load_ex_mem    = ctl.load_ex_mem;
    assign load_mem_wb    = ctl.load_mem_wb;
    assign kill_if_id     = ctl.kill_if_id;
    assign kill_id_ex     = ctl.kill_id_ex;
    assign redirect_valid = ctl.redirect_valid;
    assign redirect_pc    = redirect_pc_c;

`ifdef PIPE_CTRL_PERF_EN
    logic in_run;
    logic win_dstall;
    logic win_istall;
    logic win_loaduse;
    logic win_mispredict;
    logic [XLEN-1:0] perf_dstall_q, perf_istall_q, perf_loaduse_q, perf_mispredict_q;

    assign in_run         = (state_q == RUN);
    assign win_dstall     = dstall;
    assign win_mispredict = in_run && !dstall && ex_mispredict;
    assign win_loaduse    = in_run && !dstall && !ex_mispredict && loaduse;
    assign win_istall     = !dstall && (!in_run || (!ex_mispredict && !loaduse && istall));

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dstall_q     <= '0;
            perf_istall_q     <= '0;
            perf_loaduse_q    <= '0;
            perf_mispredict_q <= '0;
        end else begin
            if (win_dstall && perf_dstall_q != '1)         perf_dstall_q     <= perf_dstall_q + XLEN'(1);
            if (win_istall && perf_istall_q != '1)         perf_istall_q     <= perf_istall_q + XLEN'(1);
            if (win_loaduse && perf_loaduse_q != '1)       perf_loaduse_q    <= perf_loaduse_q + XLEN'(1);
            if (win_mispredict && perf_mispredict_q != '1) perf_mispredict_q <= perf_mispredict_q + XLEN'(1);
        end
    end

    assign perf_dstall     = perf_dstall_q;
    assign perf_istall     = perf_istall_q;
    assign perf_loaduse    = perf_loaduse_q;
    assign perf_mispredict = perf_mispredict_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl: hazards, stalls, mispredict redirect,
// drain/redirect sequencing and reset mid-drain.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read, imem_resp, dmem_req, dmem_resp;
    logic        id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]  id_rs1, id_rs2;
    logic        ex_valid, ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_mispredict;
    logic [31:0] ex_target;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        kill_if_id, kill_id_ex, redirect_valid;
    logic [31:0] redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_dstall, perf_istall, perf_loaduse, perf_mispredict;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .id_valid(id_valid), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_mispredict(ex_mispredict), .ex_target(ex_target),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .kill_if_id(kill_if_id), .kill_id_ex(kill_id_ex),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_dstall(perf_dstall), .perf_istall(perf_istall),
        .perf_loaduse(perf_loaduse), .perf_mispredict(perf_mispredict)
`endif
    );

    // Control bits {load_pc, if_id, id_ex, ex_mem, mem_wb, kill_if_id, kill_id_ex, redirect_valid}
    localparam logic [7:0] C_RUN   = 8'b11111_00_0;
    localparam logic [7:0] C_RST   = 8'b00000_11_0;
    localparam logic [7:0] C_FREEZ = 8'b00000_00_0;
    localparam logic [7:0] C_LDUSE = 8'b00111_01_0;
    localparam logic [7:0] C_ISTL  = 8'b01111_10_0;
    localparam logic [7:0] C_MPRD  = 8'b11111_11_1;
    localparam logic [7:0] C_MPDR  = 8'b01111_11_0;
    localparam logic [7:0] C_DRAIN = 8'b01111_10_0;
    localparam logic [7:0] C_DRDS  = 8'b00000_10_0;
    localparam logic [7:0] C_REDIR = 8'b11111_10_1;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got ctl=%b pc=%h, want ctl=%b pc=%h",
                     tag, obs[39:32], obs[31:0], exp[39:32], exp[31:0]);
        end
    endtask

    // Sample mid-cycle; redirect_pc only matters while redirecting or in reset.
    task automatic expect_out(input string tag, input logic [7:0] c, input logic [31:0] pc);
        logic [31:0] obs_pc;
        @(negedge clk);
        obs_pc = (redirect_valid || rst) ? redirect_pc : 32'h0;
        check(tag, {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                    kill_if_id, kill_id_ex, redirect_valid, obs_pc}, {c, pc});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_mem_read = 0; ex_rd = 0; ex_mispredict = 0; ex_target = 0;
    endtask

    task automatic hazard(input logic [4:0] rd, input logic u1, input logic [4:0] r1,
                          input logic u2, input logic [4:0] r2);
        ex_valid = 1; ex_mem_read = 1; ex_rd = rd; id_valid = 1;
        id_uses_rs1 = u1; id_rs1 = r1; id_uses_rs2 = u2; id_rs2 = r2;
    endtask

    // Mispredict with I-cache busy, then 'n' stalled drain cycles with a decoy target.
    task automatic enter_drain(input logic [31:0] tgt, input int n);
        idle(); ex_mispredict = 1; ex_target = tgt; imem_read = 1;
        expect_out("mp_istall", C_MPDR, 32'h0);
        ex_mispredict = 0; ex_target = 32'hDEAD_BEEF;
        for (int i = 0; i < n; i++) expect_out("drain_hold", C_DRAIN, 32'h0);
    endtask

    initial begin
        idle();
        rst = 1;
        expect_out("reset_outputs", C_RST, 32'h0);
        expect_out("reset_outputs2", C_RST, 32'h0);
        rst = 0;
        expect_out("run_idle", C_RUN, 32'h0);

        // Load-use hazard: one bubble, then the load has moved on.
        hazard(5'd5, 1, 5'd5, 0, 5'd0);
        expect_out("loaduse_rs1", C_LDUSE, 32'h0);
        ex_mem_read = 0;
        expect_out("loaduse_gone", C_RUN, 32'h0);
        hazard(5'd0, 1, 5'd0, 0, 5'd0);
        expect_out("loaduse_x0", C_RUN, 32'h0);
        hazard(5'd7, 0, 5'd7, 1, 5'd7);
        expect_out("loaduse_rs2", C_LDUSE, 32'h0);
        hazard(5'd7, 0, 5'd7, 0, 5'd7);
        expect_out("loaduse_unused", C_RUN, 32'h0);
        hazard(5'd9, 1, 5'd9, 0, 5'd0); id_valid = 0;
        expect_out("loaduse_id_inval", C_RUN, 32'h0);

        // D-cache stall for 4 cycles, then the response.
        idle(); dmem_req = 1;
        for (int i = 0; i < 4; i++) expect_out("dstall", C_FREEZ, 32'h0);
        dmem_resp = 1;
        expect_out("dstall_resp", C_RUN, 32'h0);

        // Instruction-cache stall alone, and loaduse beating it.
        idle(); imem_read = 1;
        expect_out("istall", C_ISTL, 32'h0);
        hazard(5'd3, 1, 5'd3, 0, 5'd0);
        expect_out("loaduse_over_istall", C_LDUSE, 32'h0);

        // Mispredict with idle I-cache: same-cycle redirect.
        idle(); ex_mispredict = 1; ex_target = 32'h60;
        expect_out("mp_redirect", C_MPRD, 32'h60);
        hazard(5'd4, 1, 5'd4, 0, 5'd0); ex_mispredict = 1; ex_target = 32'h64;
        expect_out("mp_over_loaduse", C_MPRD, 32'h64);
        idle();
        expect_out("mp_after", C_RUN, 32'h0);

        // Mispredict held under dstall, serviced once it clears.
        dmem_req = 1; ex_mispredict = 1; ex_target = 32'h70;
        expect_out("mp_under_dstall", C_FREEZ, 32'h0);
        dmem_resp = 1;
        expect_out("mp_after_dstall", C_MPRD, 32'h70);
        idle();

        // Mispredict with 3-cycle istall: drain, then redirect from stored target.
        enter_drain(32'h80, 2);
        imem_resp = 1;
        expect_out("drain_redirect", C_REDIR, 32'h80);
        idle();
        expect_out("drain_back_run", C_RUN, 32'h0);

        // Response arrives under dstall: hold in REDIRECT until dstall releases.
        enter_drain(32'h90, 1);
        imem_resp = 1; dmem_req = 1;
        expect_out("drain_resp_dstall", C_DRDS, 32'h0);
        imem_read = 0; imem_resp = 0;
        expect_out("redirect_hold", C_DRDS, 32'h0);
        dmem_resp = 1;
        expect_out("redirect_fire", C_REDIR, 32'h90);
        idle();
        expect_out("redirect_back_run", C_RUN, 32'h0);

        // Reset mid-drain discards the pending target.
        enter_drain(32'hA0, 1);
        rst = 1;
        expect_out("rst_in_drain", C_RST, 32'h0);
        rst = 0; imem_read = 1; imem_resp = 1;
        expect_out("rst_drain_run", C_RUN, 32'h0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
